// File: rtl/midi_rx.sv
// midi_rx: serial MIDI receiver decoding Note On/Off for one channel into note/gate strobes
module midi_rx #(
    parameter int         CLK_HZ  = 50_000_000,
    parameter int         BAUD    = 31_250,
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic [7:0] amplitude,
    output logic       frame_err
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB) + 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          s1, s2, prev;
    logic          byte_valid, byte_bad;
    logic [7:0]    status;
    logic          dcnt;
    logic [6:0]    note;
    logic          is_note, len1, chan_ok, on;

    assign is_note = status[6:5] == 2'b00;
    assign len1    = status[6:5] == 2'b10;
    assign chan_ok = OMNI || status[3:0] == CHANNEL;
    assign on      = status[4] && shreg[6:0] != 7'd0;

    // two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s1, s2, prev} <= 3'b111;
        else        {s1, s2, prev} <= {midi_in, s1, s2};
    end

    // UART receive FSM: centre-sample start, 8 data bits LSB first, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_bad   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_bad   <= 1'b0;
            case (state)
                IDLE: if (prev && !s2) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == HALF_LAST) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= s2 ? IDLE : DATA;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == LAST) begin
                    cnt     <= '0;
                    shreg   <= {s2, shreg[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == LAST) begin
                    cnt        <= '0;
                    byte_valid <= s2;
                    byte_bad   <= !s2;
                    state      <= IDLE;
                end else cnt <= cnt + 1'b1;
            endcase
        end
    end

    // running-status parser emitting note on/off strobes for the selected channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status     <= '0;
            dcnt       <= 1'b0;
            note       <= '0;
            midi_data  <= '0;
            midi_valid <= 1'b0;
            amplitude  <= '0;
            frame_err  <= 1'b0;
        end else begin
            midi_valid <= 1'b0;
            frame_err  <= byte_bad;
            if (byte_valid) begin
                if (shreg[7:4] == 4'hF) begin
                    if (!shreg[3]) begin
                        status <= '0;
                        dcnt   <= 1'b0;
                    end
                end else if (shreg[7]) begin
                    status <= shreg;
                    dcnt   <= 1'b0;
                end else if (status[7] && !len1) begin
                    if (!dcnt) begin
                        note <= shreg[6:0];
                        dcnt <= 1'b1;
                    end else begin
                        dcnt <= 1'b0;
                        if (is_note && chan_ok) begin
                            midi_valid <= 1'b1;
                            midi_data  <= {on, note};
                            if (on) amplitude <= {shreg[6:0], shreg[6]};
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: directed serial-stimulus bench for midi_rx
module tb_midi_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_in = 1'b1;
    logic [7:0] d0, a0, d1, a1;
    logic       v0, fe0, v1, fe1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int nv0 = 0, nv1 = 0, nfe = 0;
    int b0, b1, bf;
    int t_start = 0, t_valid = 0;
    logic [7:0] ld0 = '0, la0 = '0, ld1 = '0;

    midi_rx #(.CLK_HZ(500_000), .BAUD(31_250), .CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
        .midi_data(d0), .midi_valid(v0), .amplitude(a0), .frame_err(fe0)
    );

    midi_rx #(.CLK_HZ(500_000), .BAUD(31_250), .CHANNEL(4'd3), .OMNI(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
        .midi_data(d1), .midi_valid(v1), .amplitude(a1), .frame_err(fe1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) begin
            nv0++;
            ld0 = d0;
            la0 = a0;
            t_valid = cyc;
        end
        if (v1) begin
            nv1++;
            ld1 = d1;
        end
        if (fe0) nfe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop, input int n);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        t_start = cyc;
        for (int i = 0; i < n; i++) begin
            midi_in = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b1, 10);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_data", 32'(d0), 0);
        check("rst_valid", 32'(v0), 0);
        check("rst_amp", 32'(a0), 0);
        check("rst_ferr", 32'(fe0), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        b0 = nv0; b1 = nv1;
        send(8'h90); send(8'h3C); send(8'h64);
        repeat (4) @(negedge clk);
        check("t1_count", nv0 - b0, 1);
        check("t1_data", 32'(ld0), 'hBC);
        check("t1_amp", 32'(la0), 'hC9);
        check("t1_latency", t_valid - t_start, 156);
        check("t1_low", 32'(v0), 0);
        check("t1_omni_count", nv1 - b1, 1);

        b0 = nv0;
        send(8'h90); send(8'h40); send(8'h7F);
        repeat (4) @(negedge clk);
        check("t2a_count", nv0 - b0, 1);
        check("t2a_data", 32'(ld0), 'hC0);
        check("t2a_amp", 32'(la0), 'hFF);
        send(8'h40); send(8'h00);
        repeat (4) @(negedge clk);
        check("t2b_count", nv0 - b0, 2);
        check("t2b_data", 32'(ld0), 'h40);
        check("t2b_amp", 32'(la0), 'hFF);

        b0 = nv0; b1 = nv1;
        send(8'h91); send(8'h3C); send(8'h64);
        repeat (4) @(negedge clk);
        check("t3_chan_count", nv0 - b0, 0);
        check("t3_omni_count", nv1 - b1, 1);
        check("t3_omni_data", 32'(ld1), 'hBC);

        b0 = nv0;
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        repeat (4) @(negedge clk);
        check("t4_rt_count", nv0 - b0, 1);
        check("t4_rt_data", 32'(ld0), 'hBC);
        check("t4_rt_amp", 32'(la0), 'hC9);

        b0 = nv0;
        send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h10);
        repeat (4) @(negedge clk);
        check("t5_abort_count", nv0 - b0, 0);

        bf = nfe; b0 = nv0;
        send_bits(8'h90, 1'b0, 10);
        midi_in = 1'b1;
        repeat (CPB) @(negedge clk);
        check("t6_ferr_count", nfe - bf, 1);
        check("t6_ferr_valid", nv0 - b0, 0);
        send(8'h3C); send(8'h64);
        repeat (4) @(negedge clk);
        check("t6_no_parse", nv0 - b0, 0);
        send(8'h80); send(8'h3C); send(8'h00);
        repeat (4) @(negedge clk);
        check("t6_off_count", nv0 - b0, 1);
        check("t6_off_data", 32'(ld0), 'h3C);
        check("t6_off_amp", 32'(la0), 'hC9);

        b0 = nv0;
        send(8'hF0); send(8'h3C); send(8'h00);
        repeat (4) @(negedge clk);
        check("t7_sysex_count", nv0 - b0, 0);

        b0 = nv0;
        send(8'h90); send(8'h3C);
        @(negedge clk);
        midi_in = 1'b0;
        repeat (3) @(negedge clk);
        midi_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(8'h64);
        repeat (4) @(negedge clk);
        check("t8_glitch_count", nv0 - b0, 1);
        check("t8_glitch_data", 32'(ld0), 'hBC);

        send(8'h90);
        send_bits(8'h3C, 1'b1, 4);
        #3 rst_n = 1'b0;
        #1;
        check("t9_rst_data", 32'(d0), 0);
        check("t9_rst_valid", 32'(v0), 0);
        check("t9_rst_amp", 32'(a0), 0);
        check("t9_rst_ferr", 32'(fe0), 0);
        midi_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        b0 = nv0;
        send(8'h3C); send(8'h64);
        repeat (4) @(negedge clk);
        check("t9_rs_cleared", nv0 - b0, 0);
        send(8'h90); send(8'h3C); send(8'h64);
        repeat (4) @(negedge clk);
        check("t9_recover", nv0 - b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
